prod_acc: RTL and testbench

PROD_ACC -- requirements
Module: prod_acc

---
 rtl/prod_acc.sv | 125 ++++++++++++
 tb/tb_prod_acc.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prod_acc.sv
// prod_acc: frame accumulator for unsigned 16-bit products.
// Sums LEN accepted products into an ACC_W-bit accumulator.
// The finished sum is held until the consumer takes it.
// A sticky flag records any carry out of the accumulator.
// Optional feature macro: PROD_ACC_SAT_EN.
//   Defined:   the accumulator clamps at its maximum on overflow.
//   Undefined: the accumulator wraps modulo 2^ACC_W.
// In both builds the overflow flag is set on overflow.
module prod_acc #(
    parameter int LEN   = 8,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             beat;
    logic             last_beat;
    logic             release_res;
    logic [ACC_W:0]   sum_wide;
    logic             carry;
    logic [ACC_W-1:0] acc_add;

    // A beat is taken only while collecting.
    // A clear in the same cycle discards the product.
    assign beat        = in_valid && (state_q == ST_ACC) && !clr;
    assign last_beat   = beat && (cnt_q == CNT_LAST);
    assign release_res = (state_q == ST_DONE) && out_ready;

    // Add with one spare bit so the carry out is visible.
    assign sum_wide = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, in_prod};
    assign carry    = sum_wide[ACC_W];

`ifdef PROD_ACC_SAT_EN
    // Clamp on carry.
    // Once at full scale, every later add carries or adds zero.
    // The accumulator therefore stays pinned for the rest of the frame.
    assign acc_add = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    // Wrap modulo 2^ACC_W. The sticky flag still records the carry.
    assign acc_add = sum_wide[ACC_W-1:0];
`endif

    // State register. Reset is asynchronous and returns to collecting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Clear overrides every handshake.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_ACC;
        end else begin
            case (state_q)
                ST_ACC:  if (last_beat)   state_d = ST_DONE;
                ST_DONE: if (release_res) state_d = ST_ACC;
                default:                  state_d = ST_ACC;
            endcase
        end
    end

    // Datapath next-state logic for the accumulator, beat counter and sticky overflow flag.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr || release_res) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (beat) begin
            acc_d = acc_add;
            ovf_d = ovf_q | carry;
            cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers. Cleared asynchronously with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Output decode. The result is visible only in DONE and is forced to zero otherwise.
    always_comb begin
        in_ready  = (state_q == ST_ACC);
        out_valid = (state_q == ST_DONE);
        out_sum   = (state_q == ST_DONE) ? acc_q : '0;
        out_ovf   = (state_q == ST_DONE) && ovf_q;
    end

endmodule

// File: tb/tb_prod_acc.sv
// Testbench for prod_acc.
// Three instances are used:
//   LEN=8,  ACC_W=20 for the main tests;
//   LEN=4,  ACC_W=20 for gapped input;
//   LEN=2,  ACC_W=16 for overflow.
// The reference model for the main instance keeps the accepted beats of the current frame in a queue.
// It computes the result from the true arithmetic total.
module tb_prod_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_clr, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
    logic [15:0] a_in_prod;
    logic [19:0] a_out_sum;

    logic        b_clr, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
    logic [15:0] b_in_prod;
    logic [19:0] b_out_sum;

    logic        c_clr, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_ovf;
    logic [15:0] c_in_prod;
    logic [15:0] c_out_sum;

    prod_acc #(.LEN(8), .ACC_W(20)) u_dut_a (
        .clk(clk), .rst(rst), .clr(a_clr), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_prod(a_in_prod), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_sum(a_out_sum), .out_ovf(a_out_ovf)
    );

    prod_acc #(.LEN(4), .ACC_W(20)) u_dut_b (
        .clk(clk), .rst(rst), .clr(b_clr), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_prod(b_in_prod), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .out_ovf(b_out_ovf)
    );

    prod_acc #(.LEN(2), .ACC_W(16)) u_dut_c (
        .clk(clk), .rst(rst), .clr(c_clr), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_prod(c_in_prod), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_sum(c_out_sum), .out_ovf(c_out_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected sum for a given true total.
    // Saturating build: clamp to the maximum.
    // Wrapping build:   reduce modulo 2^w.
    function automatic logic [31:0] ref_sum(input longint total, input int w);
        longint mx = (longint'(1) << w) - 1;
        longint t  = total & mx;
        if (total <= mx) return t[31:0];
`ifdef PROD_ACC_SAT_EN
        return mx[31:0];
`else
        return t[31:0];
`endif
    endfunction

    function automatic bit ref_ovf(input longint total, input int w);
        return total > ((longint'(1) << w) - 1);
    endfunction

    // Reference model of instance A.
    int          m_beats[$];
    bit          m_done;
    logic [31:0] m_sum;
    bit          m_ovf;

    task automatic model_reset();
        m_beats.delete();
        m_done = 0;
        m_sum  = 0;
        m_ovf  = 0;
    endtask

    task automatic model_a(input bit clr, input bit v, input logic [15:0] p, input bit ordy);
        longint tot;
        if (clr) begin
            model_reset();
        end else if (m_done) begin
            if (ordy) model_reset();
        end else if (v) begin
            m_beats.push_back(int'(p));
            if (m_beats.size() == 8) begin
                tot = 0;
                foreach (m_beats[i]) tot += longint'(m_beats[i]);
                m_done = 1;
                m_sum  = ref_sum(tot, 20);
                m_ovf  = ref_ovf(tot, 20);
            end
        end
    endtask

    // One clock of instance A.
    // Called at a falling edge; returns at the next falling edge.
    task automatic cyc_a(input bit clr, input bit v, input logic [15:0] p, input bit ordy);
        a_clr = clr; a_in_valid = v; a_in_prod = p; a_out_ready = ordy;
        @(posedge clk);
        model_a(clr, v, p, ordy);
        @(negedge clk);
    endtask

    task automatic chk_model_a(input string tag);
        check({tag, " in_ready"},  a_in_ready,  !m_done);
        check({tag, " out_valid"}, a_out_valid, m_done);
        check({tag, " out_sum"},   a_out_sum,   m_done ? m_sum : 32'd0);
        check({tag, " out_ovf"},   a_out_ovf,   m_done && m_ovf);
    endtask

    typedef struct {
        bit          clr;
        bit          v;
        logic [15:0] p;
        bit          ordy;
        bit          e_ir;
        bit          e_ov;
        logic [19:0] e_sum;
        bit          e_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input bit clr, input bit v, input logic [15:0] p, input bit ordy,
                           input bit e_ir, input bit e_ov, input logic [19:0] e_sum, input bit e_ovf);
        vec_t r;
        r.clr = clr; r.v = v; r.p = p; r.ordy = ordy;
        r.e_ir = e_ir; r.e_ov = e_ov; r.e_sum = e_sum; r.e_ovf = e_ovf;
        tbl.push_back(r);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, " rst in_ready"},  a_in_ready,  1'b1);
        check({tag, " rst out_valid"}, a_out_valid, 1'b0);
        check({tag, " rst out_sum"},   a_out_sum,   32'd0);
        check({tag, " rst out_ovf"},   a_out_ovf,   1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] p0, p1;
        rst = 1'b1;
        a_clr = 0; a_in_valid = 0; a_in_prod = 0; a_out_ready = 0;
        b_clr = 0; b_in_valid = 0; b_in_prod = 0; b_out_ready = 0;
        c_clr = 0; c_in_valid = 0; c_in_prod = 0; c_out_ready = 0;
        model_reset();

        // Full-scale frame, then backpressure, then a stalled upstream beat.
        for (int i = 0; i < 8; i++)
            add_vec(0, 1, 16'hFE01, 0, i < 7, i == 7, (i == 7) ? 20'h7F008 : 20'h0, 0);
        for (int i = 0; i < 5; i++)
            add_vec(0, 1, 16'h1234, 0, 0, 1, 20'h7F008, 0);
        add_vec(0, 1, 16'h1234, 1, 1, 0, 20'h0, 0);
        for (int i = 0; i < 8; i++)
            add_vec(0, 1, 16'h0001, 0, i < 7, i == 7, (i == 7) ? 20'd8 : 20'd0, 0);
        add_vec(0, 0, 16'h0000, 1, 1, 0, 20'h0, 0);

        // Reset state of all instances.
        repeat (2) @(negedge clk);
        check("reset a in_ready",  a_in_ready,  1'b1);
        check("reset a out_valid", a_out_valid, 1'b0);
        check("reset a out_sum",   a_out_sum,   32'd0);
        check("reset a out_ovf",   a_out_ovf,   1'b0);
        check("reset b in_ready",  b_in_ready,  1'b1);
        check("reset c out_valid", c_out_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven vectors.
        foreach (tbl[i]) begin
            cyc_a(tbl[i].clr, tbl[i].v, tbl[i].p, tbl[i].ordy);
            check($sformatf("vec%0d in_ready", i),  a_in_ready,  tbl[i].e_ir);
            check($sformatf("vec%0d out_valid", i), a_out_valid, tbl[i].e_ov);
            check($sformatf("vec%0d out_sum", i),   a_out_sum,   tbl[i].e_sum);
            check($sformatf("vec%0d out_ovf", i),   a_out_ovf,   tbl[i].e_ovf);
        end

        // An asynchronous reset while the result is held drops outputs immediately.
        for (int i = 0; i < 8; i++) cyc_a(0, 1, 16'd5, 0);
        check("done before rst out_sum", a_out_sum, 32'd40);
        pulse_reset("in done");
        chk_model_a("after rst");

        // Reset mid-frame discards the partial sum.
        for (int i = 0; i < 3; i++) cyc_a(0, 1, 16'h0100, 0);
        pulse_reset("mid frame");
        for (int i = 0; i < 8; i++) cyc_a(0, 1, 16'h0001, 0);
        check("rst mid frame out_valid", a_out_valid, 1'b1);
        check("rst mid frame out_sum",   a_out_sum,   32'd8);
        cyc_a(0, 0, 16'h0, 1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            cyc_a($urandom_range(0, 39) == 0, ($urandom % 4) != 0,
                  16'($urandom), ($urandom % 3) != 0);
            chk_model_a($sformatf("rand%0d", i));
        end

        // Clear with a simultaneous beat mid-frame, then clear while the result is held.
        cyc_a(1, 0, 16'h0, 0);
        for (int i = 0; i < 5; i++) cyc_a(0, 1, 16'd1, 0);
        cyc_a(1, 1, 16'h5555, 0);
        for (int i = 0; i < 7; i++) cyc_a(0, 1, 16'd2, 0);
        check("clr frame early valid", a_out_valid, 1'b0);
        cyc_a(0, 1, 16'd2, 0);
        check("clr frame out_valid", a_out_valid, 1'b1);
        check("clr frame out_sum",   a_out_sum,   32'd16);
        cyc_a(1, 1, 16'd7, 1);
        check("clr in done in_ready", a_in_ready, 1'b1);
        check("clr in done out_sum",  a_out_sum,  32'd0);
        for (int i = 0; i < 8; i++) cyc_a(0, 1, 16'd3, 0);
        check("after clr done out_sum", a_out_sum, 32'd24);
        cyc_a(0, 0, 16'h0, 1);
        chk_model_a("clr seq end");

        // Gapped input on the LEN=4 instance.
        for (int k = 1; k <= 4; k++) begin
            b_in_valid = 1; b_in_prod = 16'(k);
            @(posedge clk); @(negedge clk);
            b_in_valid = 0;
            check($sformatf("gap beat%0d out_valid", k), b_out_valid, k == 4);
            if (k < 4) begin
                repeat (2) @(negedge clk);
                check($sformatf("gap idle%0d out_valid", k), b_out_valid, 1'b0);
            end
        end
        check("gap out_sum", b_out_sum, 32'd10);
        check("gap out_ovf", b_out_ovf, 1'b0);
        b_out_ready = 1;
        @(posedge clk); @(negedge clk);
        b_out_ready = 0;
        check("gap release in_ready", b_in_ready, 1'b1);

        // Overflow on the ACC_W=16, LEN=2 instance:
        // a directed frame first, then random frames.
        for (int f = 0; f < 31; f++) begin
            p0 = (f == 0) ? 16'hFFFF : 16'($urandom);
            p1 = (f == 0) ? 16'hFFFF : 16'($urandom);
            c_in_valid = 1; c_in_prod = p0;
            @(posedge clk); @(negedge clk);
            check($sformatf("ovf%0d mid out_valid", f), c_out_valid, 1'b0);
            c_in_prod = p1;
            @(posedge clk); @(negedge clk);
            c_in_valid = 0;
            check($sformatf("ovf%0d out_valid", f), c_out_valid, 1'b1);
            check($sformatf("ovf%0d out_sum", f), c_out_sum,
                  ref_sum(longint'(p0) + longint'(p1), 16));
            check($sformatf("ovf%0d out_ovf", f), c_out_ovf,
                  ref_ovf(longint'(p0) + longint'(p1), 16));
            c_out_ready = 1;
            @(posedge clk); @(negedge clk);
            c_out_ready = 0;
            check($sformatf("ovf%0d release out_ovf", f), c_out_ovf, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
